// File: rtl/dma_pkg.sv
// Shared types and constants for the speaker playback DMA.
//   spk_dma_state_t : control FSM states
//   WORD_BYTES      : bytes per audio sample on the bus
//   BYTEEN_ALL      : byte enable driven with every read request
//   burst_size()    : words in the next burst, min(max_len, words_left)
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } spk_dma_state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    function automatic logic [2:0] burst_size(input logic [31:0] left,
                                               input logic [2:0]  max_len);
        logic [2:0] result;
        if (left < {29'd0, max_len}) begin
            result = left[2:0];
        end else begin
            result = max_len;
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO holding samples between the bus and the DAC.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write one entry (accepted when not full, or full with pop)
//   pop        : drop the head entry (ignored when empty)
//   rdata      : current head entry, valid while !empty
//   count      : number of stored entries
//   full/empty : occupancy flags
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == DEPTH_C);
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    // A full FIFO may still take a write when the head leaves in the same cycle.
    assign do_push_s = push && (!full || pop);
    assign do_pop_s  = pop && !empty;

    // Storage array and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
        end
    end

    // Read pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spk_dma.sv
// Avalon-MM burst read master feeding the speaker/DAC path.
// Fetches number_samples 32-bit words starting at start_address and hands
// one word per spk_ready pulse to the DAC through a small sample FIFO.
// Ports:
//   CLK, RESET          : clock, asynchronous active-low reset
//   AM_*                : Avalon-MM read master (burst capable)
//   start               : pulse, latches start_address / number_samples
//   spk_ready           : pulse from DAC requesting the next sample
//   spk_data, spk_valid : sample and one-cycle update strobe
//   FINISHED            : level, every sample has been delivered
//   underrun_count      : only with SPK_DMA_UNDERRUN_CNT_EN defined; counts
//                         spk_ready pulses that found the FIFO empty
// Build option: define SPK_DMA_UNDERRUN_CNT_EN to add underrun_count.
module spk_dma
    import dma_pkg::*;
#(
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] AM_ADDR,
    output logic [2:0]  AM_BURSTCOUNT,
    output logic        AM_READ,
    output logic [3:0]  AM_BYTEENABLE,
    input  logic        AM_WAITREQUEST,
    input  logic [31:0] AM_READDATA,
    input  logic        AM_READDATAVALID,
    input  logic        start,
    input  logic [31:0] start_address,
    input  logic [31:0] number_samples,
    input  logic        spk_ready,
    output logic [31:0] spk_data,
    output logic        spk_valid,
    output logic        FINISHED
`ifdef SPK_DMA_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_count
`endif
);

    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] BURST_MAX = 3'(BURST_LEN);

    spk_dma_state_t state_r, state_n;

    logic [31:0] am_addr_r;
    logic [2:0]  am_bc_r;
    logic        am_read_r;
    logic [3:0]  am_be_r;
    logic [31:0] req_left_r;
    logic [31:0] out_left_r;
    logic [3:0]  pending_r;
    logic [31:0] spk_data_r;
    logic        spk_valid_r;
    logic        finished_r;

    logic          active_s, start_hit_s, accept_s, hold_s, push_s, pop_s;
    logic          eligible_s, read_n_s;
    logic [2:0]    bc_n_s, bc_after_s;
    logic [31:0]   req_after_s, out_after_s, addr_after_s, free_after_s;
    logic [3:0]    pending_after_s;
    logic [CW-1:0] fifo_count_s, count_after_s;
    logic [31:0]   fifo_rdata_s;
    logic          fifo_full_s, fifo_empty_s;

    assign active_s    = (state_r == ISSUE) || (state_r == DRAIN);
    assign start_hit_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign accept_s    = am_read_r && !AM_WAITREQUEST;
    assign hold_s      = am_read_r && AM_WAITREQUEST;
    // Returns only count while words are outstanding; stale beats after a
    // reset find pending at zero and are dropped.
    assign push_s      = AM_READDATAVALID && active_s && (pending_r != 4'd0)
                         && (!fifo_full_s || pop_s);
    assign pop_s       = spk_ready && active_s && !fifo_empty_s;

    // Counter values as they will be after this edge; the next burst is
    // judged against these so a back-to-back burst never overcommits.
    assign req_after_s     = accept_s ? (req_left_r - 32'(am_bc_r)) : req_left_r;
    assign addr_after_s    = accept_s ? (am_addr_r + 32'(am_bc_r) * 32'(WORD_BYTES))
                                      : am_addr_r;
    assign out_after_s     = pop_s ? (out_left_r - 32'd1) : out_left_r;
    assign pending_after_s = pending_r + (accept_s ? 4'(am_bc_r) : 4'd0)
                                       - (push_s ? 4'd1 : 4'd0);
    assign count_after_s   = fifo_count_s + (push_s ? CW'(1) : CW'(0))
                                          - (pop_s  ? CW'(1) : CW'(0));
    assign bc_after_s      = burst_size(req_after_s, BURST_MAX);
    assign free_after_s    = 32'(FIFO_DEPTH) - 32'(count_after_s);
    assign eligible_s      = (state_r == ISSUE) && (req_after_s != 32'd0) &&
                             (free_after_s >= 32'(pending_after_s) + 32'(bc_after_s));

    sample_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (AM_READDATA),
        .rdata (fifo_rdata_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Control FSM next-state decode.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_n = (number_samples == 32'd0) ? DONE : ISSUE;
                end else begin
                    state_n = state_r;
                end
            end
            ISSUE: begin
                if (req_after_s == 32'd0) begin
                    state_n = DRAIN;
                end else begin
                    state_n = ISSUE;
                end
            end
            DRAIN: begin
                if (out_after_s == 32'd0) begin
                    state_n = DONE;
                end else begin
                    state_n = DRAIN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Read request decode: freeze during a stall, else issue when eligible.
    always_comb begin
        read_n_s = 1'b0;
        bc_n_s   = 3'd0;
        if (hold_s) begin
            read_n_s = 1'b1;
            bc_n_s   = am_bc_r;
        end else if (eligible_s) begin
            read_n_s = 1'b1;
            bc_n_s   = bc_after_s;
        end else begin
            read_n_s = 1'b0;
            bc_n_s   = 3'd0;
        end
    end

    // FSM state, bus request registers and FINISHED flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r    <= IDLE;
            am_read_r  <= 1'b0;
            am_bc_r    <= 3'd0;
            am_be_r    <= 4'h0;
            finished_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            am_read_r  <= read_n_s;
            am_bc_r    <= bc_n_s;
            am_be_r    <= read_n_s ? BYTEEN_ALL : 4'h0;
            finished_r <= (state_n == DONE) && !start_hit_s;
        end
    end

    // Transfer counters and burst address.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            am_addr_r  <= 32'd0;
            req_left_r <= 32'd0;
            out_left_r <= 32'd0;
            pending_r  <= 4'd0;
        end else if (start_hit_s) begin
            am_addr_r  <= start_address;
            req_left_r <= number_samples;
            out_left_r <= number_samples;
            pending_r  <= pending_after_s;
        end else begin
            am_addr_r  <= addr_after_s;
            req_left_r <= req_after_s;
            out_left_r <= out_after_s;
            pending_r  <= pending_after_s;
        end
    end

    // DAC-side sample register: loads the FIFO head on each pop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            spk_data_r  <= 32'd0;
            spk_valid_r <= 1'b0;
        end else begin
            spk_valid_r <= pop_s;
            if (pop_s) begin
                spk_data_r <= fifo_rdata_s;
            end
        end
    end

`ifdef SPK_DMA_UNDERRUN_CNT_EN
    logic        underrun_s;
    logic [15:0] underrun_cnt_r;

    assign underrun_s = spk_ready && active_s && fifo_empty_s;

    // Saturating count of requests that found no sample ready.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            underrun_cnt_r <= 16'd0;
        end else if (start_hit_s) begin
            underrun_cnt_r <= 16'd0;
        end else if (underrun_s && (underrun_cnt_r != 16'hFFFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 16'd1;
        end
    end

    assign underrun_count = underrun_cnt_r;
`endif

    assign AM_ADDR       = am_addr_r;
    assign AM_BURSTCOUNT = am_bc_r;
    assign AM_READ       = am_read_r;
    assign AM_BYTEENABLE = am_be_r;
    assign spk_data      = spk_data_r;
    assign spk_valid     = spk_valid_r;
    assign FINISHED      = finished_r;

endmodule
